dino_obstacle_collide: RTL
==========================

// Module: dino_obstacle_collide
// PURPOSE
//  Consumer of the dino jump block's dinoY. Scrolls one cactus leftward and checks overlap with the dino's box.
//  Counts cleared obstacles and runs the IDLE/RUN/DEAD game FSM. Feeds the renderer (obst_x/obst_valid) and score display.
//  Screen coords: y grows downward; dinoY is the dino's bottom edge; GROUND_Y is the resting value.
// PARAMETERS
//  GROUND_Y     181     dinoY when dino is on the ground
//  OBST_H       20      cactus height; cactus spans y (GROUND_Y-OBST_H, GROUND_Y]
//  DINO_X       40      dino left edge x (fixed)
//  DINO_W       16      dino width
//  OBST_W       10      cactus width
//  SCREEN_W     240     spawn x = SCREEN_W-1
//  STEP_DIV     120000  clocks per 1-px scroll step at level 0 (12 MHz -> 100 px/s)
//  SPEEDUP_PTS  10      points per speed level
//  MAX_LEVEL    3       level saturates here
//  LFSR_SEED    8'hA5   gap LFSR reset value; must be nonzero
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  start       in   1   jump button (level); rising edge used
//  dinoY       in   8   dino bottom-edge y from the jump block
//  obst_x      out  8   cactus left-edge x
//  obst_valid  out  1   cactus on screen
//  score       out  14  cleared obstacles, binary, saturates at 9999
//  level       out  2   speed level 0..MAX_LEVEL
//  running     out  1   FSM in RUN
//  game_over   out  1   FSM in DEAD
// BEHAVIOUR
//  Reset (synchronous, rst=1 at a clk edge): state=IDLE; obst_x=0, obst_valid=0, score=0, level=0, running=0, game_over=0.
//  - Reset also: LFSR=LFSR_SEED, prescaler=0, gap=0, start_q=0. Reset mid-game has the same effect.
//  start_edge = start & ~start_q; start_q is registered every clk.
//  IDLE --start_edge--> RUN: score=0, level=0, prescaler=0, obst_x=SCREEN_W-1, obst_valid=1 on that edge.
//  RUN --hit--> DEAD: game_over=1 and running=0 on the edge after hit is seen; obst_x and score freeze.
//  DEAD --start_edge--> RUN: same initialisation as from IDLE.
//  tick: 1-clk pulse, RUN only, when prescaler == (STEP_DIV>>level)-1; prescaler then wraps to 0.
//  On tick with obst_valid=1 and obst_x>0: obst_x decrements by 1.
//  On tick with obst_valid=1 and obst_x==0:
//  - obst_valid=0; score+1 (saturates at 9999); gap=8+LFSR[4:0] ticks.
//  - pts counter +1; when it reaches SPEEDUP_PTS it clears and level+1 (saturates at MAX_LEVEL).
//  On tick with obst_valid=0: gap decrements; a tick that finds gap==0 spawns obst_x=SCREEN_W-1, obst_valid=1.
//  hit (combinational, RUN only) = obst_valid & x_overlap & (dinoY > GROUND_Y-OBST_H).
//  - x_overlap: obst_x <= DINO_X+DINO_W-1 and obst_x+OBST_W-1 >= DINO_X, computed 9 bits wide (no wrap).
//  - dinoY == GROUND_Y-OBST_H means clear, not hit.
//  Same-cycle hit and tick: hit wins; no move, no score.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk outside reset.
//  Level changes take effect on the next prescaler compare; the prescaler is not cleared.
//  start held high produces only one edge; no auto-restart.
// TESTING (override STEP_DIV=4 unless noted)
//  1 Hold rst 2 clks -> all outputs 0, state IDLE; start held low 100 clks -> still IDLE, obst_valid=0.
//  2 start pulse, dinoY=181 -> obst_x=239 and running=1 next edge, -1 every 4 clks.
//    -> at obst_x=55 game_over=1 one clk later; obst_x stays 55; score=0.
//  3 dinoY=150 throughout -> obst_x reaches 0, then score=1 and obst_valid=0.
//    -> respawn at 239 after 8..39 ticks; gap matches LFSR model.
//  4 dinoY at boundary: 161 while overlapping -> no hit; 162 -> hit.
//    -> hit stays latched in DEAD after dinoY returns to 150.
//  5 Clear 10 obstacles -> score=10, level=1, then ticks every 2 clks.
//    -> STEP_DIV=32, 30+ points: level saturates at 3 (tick every 4 clks).
//  6 rst mid-RUN at obst_x=100 -> IDLE with all outputs 0 next edge.
//    start in DEAD -> RUN with score=0, obst_x=239.

Source files
------------

// File: rtl/dino_obstacle_collide_if.sv
// Game-state bundle between the jump block / button, the obstacle and
// collision core, and the renderer / score display.
//   start      : jump button level (the core uses its rising edge)
//   dinoY      : dino bottom-edge y from the jump block (y grows downward)
//   obst_x     : cactus left-edge x
//   obst_valid : cactus on screen
//   score      : cleared obstacles, binary, saturating at 9999
//   level      : speed level
//   running    : game FSM in RUN
//   game_over  : game FSM in DEAD
// master = stimulus / jump-block side, slave = the collide core.
interface dino_obstacle_collide_if;
  logic        start;
  logic [7:0]  dinoY;
  logic [7:0]  obst_x;
  logic        obst_valid;
  logic [13:0] score;
  logic [1:0]  level;
  logic        running;
  logic        game_over;

  modport master (
    output start, dinoY,
    input  obst_x, obst_valid, score, level, running, game_over
  );

  modport slave (
    input  start, dinoY,
    output obst_x, obst_valid, score, level, running, game_over
  );
endinterface

// File: rtl/dino_obstacle_collide.sv
// Scrolls one cactus leftward, checks it against the dino's bounding box,
// counts cleared obstacles, raises the speed level every SPEEDUP_PTS points
// and runs the IDLE/RUN/DEAD game FSM.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : slave side of dino_obstacle_collide_if (start/dinoY in;
//         obst_x, obst_valid, score, level, running, game_over out)
// All outputs come straight from flops.
module dino_obstacle_collide #(
  parameter int         GROUND_Y    = 181,
  parameter int         OBST_H      = 20,
  parameter int         DINO_X      = 40,
  parameter int         DINO_W      = 16,
  parameter int         OBST_W      = 10,
  parameter int         SCREEN_W    = 240,
  parameter int         STEP_DIV    = 120000,
  parameter int         SPEEDUP_PTS = 10,
  parameter int         MAX_LEVEL   = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  dino_obstacle_collide_if.slave bus
);

  localparam int PW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PTW = (SPEEDUP_PTS > 1) ? $clog2(SPEEDUP_PTS) : 1;

  localparam logic [7:0]     SPAWN_X   = 8'(SCREEN_W - 1);
  localparam logic [7:0]     CLEAR_Y   = 8'(GROUND_Y - OBST_H);
  localparam logic [8:0]     DINO_R    = 9'(DINO_X + DINO_W - 1);
  localparam logic [8:0]     DINO_L    = 9'(DINO_X);
  localparam logic [8:0]     OBST_SPAN = 9'(OBST_W - 1);
  localparam logic [13:0]    SCORE_MAX = 14'd9999;
  localparam logic [1:0]     LEVEL_MAX = 2'(MAX_LEVEL);
  localparam logic [PTW-1:0] PTS_LAST  = PTW'(SPEEDUP_PTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_e;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_e         state_q, state_d;
  logic           start_q;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     obst_x_q, obst_x_d;
  logic           obst_valid_q, obst_valid_d;
  logic [13:0]    score_q, score_d;
  logic [1:0]     level_q, level_d;
  logic [PTW-1:0] pts_q, pts_d;
  logic [5:0]     gap_q, gap_d;
  logic           running_q, running_d;
  logic           game_over_q, game_over_d;

  logic           start_edge_s;
  logic           tick_s;
  logic           hit_s;
  logic           x_overlap_s;
  logic           dino_low_s;
  logic [PW-1:0]  step_lim_s;

  assign start_edge_s = bus.start & ~start_q;

  // Next-state, scroll, scoring and collision logic.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_next(lfsr_q);
    presc_d      = presc_q;
    obst_x_d     = obst_x_q;
    obst_valid_d = obst_valid_q;
    score_d      = score_q;
    level_d      = level_q;
    pts_d        = pts_q;
    gap_d        = gap_q;
    tick_s       = 1'b0;
    hit_s        = 1'b0;

    // Overlap is evaluated 9 bits wide so obst_x + OBST_W - 1 cannot wrap.
    x_overlap_s = ({1'b0, obst_x_q} <= DINO_R) &&
                  (({1'b0, obst_x_q} + OBST_SPAN) >= DINO_L);
    // dinoY equal to the cactus top counts as clear.
    dino_low_s  = (bus.dinoY > CLEAR_Y);
    // A level change lands on a tick, where the prescaler has just wrapped,
    // so the shorter period never sees a prescaler already past its limit.
    step_lim_s  = PW'((STEP_DIV >> level_q) - 1);

    case (state_q)
      S_IDLE, S_DEAD: begin
        if (start_edge_s) begin
          state_d      = S_RUN;
          score_d      = 14'd0;
          level_d      = 2'd0;
          pts_d        = '0;
          presc_d      = '0;
          gap_d        = 6'd0;
          obst_x_d     = SPAWN_X;
          obst_valid_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        hit_s  = obst_valid_q & x_overlap_s & dino_low_s;
        tick_s = (presc_q == step_lim_s);
        if (hit_s) begin
          // Collision beats a coincident tick: nothing moves or scores.
          state_d = S_DEAD;
        end else begin
          presc_d = tick_s ? '0 : presc_q + PW'(1);
          if (tick_s && obst_valid_q) begin
            if (obst_x_q != 8'd0) begin
              obst_x_d = obst_x_q - 8'd1;
            end else begin
              obst_valid_d = 1'b0;
              score_d      = (score_q == SCORE_MAX) ? score_q : score_q + 14'd1;
              gap_d        = 6'd8 + {1'b0, lfsr_q[4:0]};
              if (pts_q == PTS_LAST) begin
                pts_d   = '0;
                level_d = (level_q == LEVEL_MAX) ? level_q : level_q + 2'd1;
              end else begin
                pts_d = pts_q + PTW'(1);
              end
            end
          end else if (tick_s) begin
            // Off-screen: count the gap down, spawn on the tick that finds it empty.
            if (gap_q == 6'd0) begin
              obst_x_d     = SPAWN_X;
              obst_valid_d = 1'b1;
            end else begin
              gap_d = gap_q - 6'd1;
            end
          end else begin
            obst_x_d = obst_x_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    running_d   = (state_d == S_RUN);
    game_over_d = (state_d == S_DEAD);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      presc_q      <= '0;
      obst_x_q     <= 8'd0;
      obst_valid_q <= 1'b0;
      score_q      <= 14'd0;
      level_q      <= 2'd0;
      pts_q        <= '0;
      gap_q        <= 6'd0;
      running_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= bus.start;
      lfsr_q       <= lfsr_d;
      presc_q      <= presc_d;
      obst_x_q     <= obst_x_d;
      obst_valid_q <= obst_valid_d;
      score_q      <= score_d;
      level_q      <= level_d;
      pts_q        <= pts_d;
      gap_q        <= gap_d;
      running_q    <= running_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.obst_x     = obst_x_q;
  assign bus.obst_valid = obst_valid_q;
  assign bus.score      = score_q;
  assign bus.level      = level_q;
  assign bus.running    = running_q;
  assign bus.game_over  = game_over_q;

endmodule
